// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer
//   Frame sequencer between a UART receiver, an ALU and a UART transmitter.
//   Collects a three-byte frame (operand A, operand B, opcode), presents the
//   latched operands/opcode to the ALU, captures the ALU result and starts a
//   transmission. An inter-byte watchdog clocked by the baud tick abandons
//   incomplete frames.
//
// Ports:
//   clk           system clock
//   i_rst_n       asynchronous active-low reset
//   i_tick        baud oversampling tick (one-cycle pulse)
//   i_rx_data     received byte, valid with i_rx_done
//   i_rx_done     byte received (one-cycle pulse)
//   i_alu_result  combinational ALU result of o_data_a/o_data_b/o_op
//   i_tx_done     transmitter finished (one-cycle pulse)
//   o_data_a      latched operand A
//   o_data_b      latched operand B
//   o_op          latched opcode (low NB_OP bits of third byte)
//   o_tx_data     byte to transmit
//   o_tx_start    start transmission (one-cycle pulse)
//   o_busy        high in every state except IDLE
//   o_timeout     frame abandoned by watchdog (one-cycle pulse)
module uart_alu_sequencer #(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int TIMEOUT_TICKS = 1600,
  parameter int NB_TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    LATCH   = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam bit                    WD_EN   = (TIMEOUT_TICKS > 0);
  localparam logic [NB_TIMEOUT-1:0] TO_LAST = NB_TIMEOUT'(TIMEOUT_TICKS - 1);

  state_t                state_q, state_d;
  logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;
  logic [NB_DATA-1:0]    data_a_q, data_a_d;
  logic [NB_DATA-1:0]    data_b_q, data_b_d;
  logic [NB_OP-1:0]      op_q, op_d;
  logic [NB_DATA-1:0]    tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;

  logic wd_active;
  logic wd_expire;

  // Watchdog only runs while waiting for the 2nd/3rd byte. A byte arriving
  // in the same cycle as the expiring tick takes priority over the timeout.
  assign wd_active = WD_EN && ((state_q == WAIT_B) || (state_q == WAIT_OP));
  assign wd_expire = wd_active && i_tick && !i_rx_done && (cnt_q == TO_LAST);

  // State and output registers
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_rx_done) state_d = WAIT_B;
      end
      WAIT_B: begin
        if (i_rx_done)      state_d = WAIT_OP;
        else if (wd_expire) state_d = IDLE;
      end
      WAIT_OP: begin
        if (i_rx_done)      state_d = LATCH;
        else if (wd_expire) state_d = IDLE;
      end
      LATCH: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d      = cnt_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = wd_expire;
    busy_d     = (state_d != IDLE);

    unique case (state_q)
      IDLE: begin
        if (i_rx_done) begin
          data_a_d = i_rx_data;
          cnt_d    = '0;
        end
      end
      WAIT_B, WAIT_OP: begin
        if (i_rx_done) begin
          if (state_q == WAIT_B) data_b_d = i_rx_data;
          else                   op_d     = i_rx_data[NB_OP-1:0];
          cnt_d = '0;
        end else if (wd_expire) begin
          cnt_d = '0;
        end else if (wd_active && i_tick) begin
          cnt_d = cnt_q + NB_TIMEOUT'(1);
        end
      end
      LATCH: begin
        // ALU inputs have been stable for a full cycle since the opcode latched.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
module tb_uart_alu_sequencer;

  logic       clk;
  logic       i_rst_n;
  logic       i_tick;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [7:0] i_alu_result;
  logic       i_tx_done;
  logic [7:0] o_data_a;
  logic [7:0] o_data_b;
  logic [5:0] o_op;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_timeout;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb[$];
  logic       prev_start = 1'b0;

  uart_alu_sequencer #(
    .NB_DATA      (8),
    .NB_OP        (6),
    .TIMEOUT_TICKS(4),
    .NB_TIMEOUT   (16)
  ) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_tick      (i_tick),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .i_alu_result(i_alu_result),
    .i_tx_done   (i_tx_done),
    .o_data_a    (o_data_a),
    .o_data_b    (o_data_b),
    .o_op        (o_op),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench ALU: add for opcode 0x20, xor otherwise
  function automatic logic [7:0] alu_model(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    return (op == 6'h20) ? (a + b) : (a ^ b);
  endfunction

  always_comb i_alu_result = alu_model(o_data_a, o_data_b, o_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every start pulse pops one expected result
  always @(negedge clk) begin
    if (o_tx_start) begin
      chk("start_width", 32'(prev_start), 32'd0);
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else                chk("tx_data", 32'(o_tx_data), 32'(sb.pop_front()));
    end
    prev_start <= o_tx_start;
  end

  // All tasks start and end at posedge+1
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rx, input logic [7:0] d, input logic tk, input logic txd);
    i_rx_done = rx;
    i_rx_data = d;
    i_tick    = tk;
    i_tx_done = txd;
    cyc();
    i_rx_done = 1'b0;
    i_tick    = 1'b0;
    i_tx_done = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic tx_done();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"},     32'(o_data_a),   32'd0);
    chk({tag, "_b"},     32'(o_data_b),   32'd0);
    chk({tag, "_op"},    32'(o_op),       32'd0);
    chk({tag, "_txd"},   32'(o_tx_data),  32'd0);
    chk({tag, "_start"}, 32'(o_tx_start), 32'd0);
    chk({tag, "_busy"},  32'(o_busy),     32'd0);
    chk({tag, "_to"},    32'(o_timeout),  32'd0);
  endtask

  // Opcode byte, latency checks, optional dropped byte in WAIT_TX, tx_done
  task automatic finish_frame(input logic [7:0] opb, input logic drop);
    logic [7:0] a_hold;
    sb.push_back(alu_model(o_data_a, o_data_b, opb[5:0]));
    rx_byte(opb);
    chk("op", 32'(o_op), 32'(opb[5:0]));
    chk("start_e0", 32'(o_tx_start), 32'd0);
    chk("busy_latch", 32'(o_busy), 32'd1);
    cyc();
    chk("start_e1", 32'(o_tx_start), 32'd1);
    chk("txd_e1", 32'(o_tx_data), 32'(alu_model(o_data_a, o_data_b, opb[5:0])));
    cyc();
    chk("start_e2", 32'(o_tx_start), 32'd0);
    chk("busy_wtx", 32'(o_busy), 32'd1);
    if (drop) begin
      a_hold = o_data_a;
      rx_byte(8'hFF);
      chk("drop_a", 32'(o_data_a), 32'(a_hold));
      chk("drop_busy", 32'(o_busy), 32'd1);
      chk("drop_start", 32'(o_tx_start), 32'd0);
    end
    tx_done();
    chk("busy_done", 32'(o_busy), 32'd0);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
    rx_byte(a);
    chk("a", 32'(o_data_a), 32'(a));
    chk("busy_wb", 32'(o_busy), 32'd1);
    rx_byte(b);
    chk("b", 32'(o_data_b), 32'(b));
    finish_frame(opb, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_all_zero(tag);
    sb.delete();
    #2;
    i_rst_n = 1'b1;
    cyc();
    chk({tag, "_post"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    i_rst_n   = 1'b0;
    i_tick    = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    #23;
    chk_all_zero("rst");
    i_rst_n = 1'b1;
    cyc();

    // Basic frame: 5 + 3
    frame(8'h05, 8'h03, 8'h20);

    // Idle noise: tx_done and ticks in IDLE do nothing
    tx_done();
    tick_n(2);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_to", 32'(o_timeout), 32'd0);
    chk("idle_start", 32'(o_tx_start), 32'd0);

    // Timeout after A only; tx_done in WAIT_B ignored
    rx_byte(8'h11);
    tx_done();
    chk("wb_txdone_busy", 32'(o_busy), 32'd1);
    tick_n(3);
    chk("to_pre", 32'(o_timeout), 32'd0);
    chk("to_pre_busy", 32'(o_busy), 32'd1);
    tick_n(1);
    chk("to_pulse", 32'(o_timeout), 32'd1);
    chk("to_busy", 32'(o_busy), 32'd0);
    chk("to_a_kept", 32'(o_data_a), 32'h11);
    cyc();
    chk("to_once", 32'(o_timeout), 32'd0);

    // Next byte is A again; B coincides with the expiring tick
    rx_byte(8'h33);
    chk("re_a", 32'(o_data_a), 32'h33);
    chk("re_busy", 32'(o_busy), 32'd1);
    tick_n(3);
    drive(1'b1, 8'h44, 1'b1, 1'b0);
    chk("race_to", 32'(o_timeout), 32'd0);
    chk("race_b", 32'(o_data_b), 32'h44);
    chk("race_busy", 32'(o_busy), 32'd1);
    tick_n(3);
    chk("cnt_clr_to", 32'(o_timeout), 32'd0);
    chk("cnt_clr_busy", 32'(o_busy), 32'd1);
    finish_frame(8'h20, 1'b0);

    // Byte dropped in WAIT_TX, then a fresh frame
    rx_byte(8'h10);
    rx_byte(8'h20);
    finish_frame(8'h01, 1'b1);
    frame(8'h01, 8'h01, 8'h20);
    chk("fresh_txd", 32'(o_tx_data), 32'h02);

    // Reset in WAIT_OP
    rx_byte(8'h55);
    rx_byte(8'h66);
    pulse_reset("rst_wop");

    // Reset while start pulse is high
    rx_byte(8'h07);
    rx_byte(8'h08);
    rx_byte(8'h20);
    @(posedge clk);
    #1;
    chk("pend_start", 32'(o_tx_start), 32'd1);
    pulse_reset("rst_wtx");

    frame(8'h0A, 8'h0B, 8'h20);
    cyc();
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Frame sequencer between the UART receiver, the ALU and the UART transmitter. It collects a three-byte command frame from the RX path: operand A, then operand B, then opcode. It presents the latched operands and opcode to the ALU, captures the ALU result and hands it to the TX path with a start/done handshake. An inter-byte watchdog, clocked by the baud-rate generator's oversampling tick, abandons incomplete frames.

## Interface
Parameters:
- NB_DATA, 8, data/operand/result width
- NB_OP, 6, opcode width; opcode = low NB_OP bits of third received byte
- TIMEOUT_TICKS, 1600, baud ticks allowed between consecutive frame bytes; 0 disables watchdog
- NB_TIMEOUT, 16, watchdog counter width; must satisfy TIMEOUT_TICKS < 2^NB_TIMEOUT

Ports:
- clk  input  1  system clock
- i_rst_n  input  1  asynchronous, active-low reset
- i_tick  input  1  baud oversampling tick from baudrate_generator, one-cycle pulse
- i_rx_data  input  NB_DATA  received byte, valid when i_rx_done=1
- i_rx_done  input  1  one-cycle pulse, byte received
- i_alu_result  input  NB_DATA  combinational ALU result of o_data_a/o_data_b/o_op
- i_tx_done  input  1  one-cycle pulse, transmitter finished byte
- o_data_a  output  NB_DATA  latched operand A
- o_data_b  output  NB_DATA  latched operand B
- o_op  output  NB_OP  latched opcode
- o_tx_data  output  NB_DATA  byte to transmit
- o_tx_start  output  1  one-cycle pulse, start transmission
- o_busy  output  1  high in every state except IDLE
- o_timeout  output  1  one-cycle pulse, frame abandoned by watchdog

## Operation
- All outputs are registered. Reset (i_rst_n=0, asynchronous) forces:
  - state=IDLE and watchdog counter=0
  - o_data_a=o_data_b=o_tx_data=0 and o_op=0
  - o_tx_start=o_busy=o_timeout=0
- States: IDLE, WAIT_B, WAIT_OP, LATCH, WAIT_TX.
- IDLE: i_rx_done -> o_data_a<=i_rx_data, counter<=0, go WAIT_B.
- WAIT_B: i_rx_done -> o_data_b<=i_rx_data, counter<=0, go WAIT_OP.
- WAIT_OP: i_rx_done -> o_op<=i_rx_data[NB_OP-1:0], go LATCH.
- Watchdog (WAIT_B, WAIT_OP only, TIMEOUT_TICKS>0):
  - Each i_tick increments the counter.
  - If i_tick arrives with counter==TIMEOUT_TICKS-1, go IDLE and pulse o_timeout for one cycle.
  - Operand registers keep their values.
  - If i_rx_done and the expiring i_tick occur in the same cycle, i_rx_done wins: byte accepted, counter<=0, no timeout.
- LATCH (exactly one cycle): o_tx_data<=i_alu_result, o_tx_start<=1, go WAIT_TX.
- WAIT_TX:
  - o_tx_start<=0, so the start pulse lasts exactly one cycle.
  - i_tx_done -> go IDLE.
- i_rx_done in LATCH or WAIT_TX is ignored (byte dropped, no state change).
- i_tx_done outside WAIT_TX is ignored.
- i_tick outside WAIT_B/WAIT_OP has no effect; the counter holds.
- o_busy<=1 on any transition out of IDLE and <=0 on entry to IDLE, so it is high throughout LATCH and WAIT_TX.

## Timing
- Operand latency: rx_done sampled at edge E -> o_data_a/o_data_b/o_op valid after E.
- Opcode byte sampled at edge E0 -> ALU inputs stable after E0 -> o_tx_data and o_tx_start=1 after E1 -> o_tx_start=0 after E2.
  - Opcode-to-start latency is 2 cycles.
  - i_alu_result must settle within one clock period.
- i_tx_done sampled at edge E -> IDLE and o_busy=0 after E; a new frame may start at the next edge.
- Timeout fires at the TIMEOUT_TICKS-th tick after the last accepted byte. o_timeout is high for exactly the one cycle after that edge.
- Reset mid-frame or mid-transmission returns to IDLE immediately; a pending o_tx_start is cleared asynchronously.

## Test plan
- Frame 0x05, 0x03, opcode 0x20 with bench ALU (A+B when op=0x20):
  - o_data_a=0x05, o_data_b=0x03, o_op=0x20
  - o_tx_data=0x08 and o_tx_start high for exactly 1 cycle, 2 cycles after the opcode rx_done
  - o_busy falls after i_tx_done
- TIMEOUT_TICKS=4; send A only, then 4 ticks:
  - o_timeout pulses once after the 4th tick, state IDLE, o_data_a retained
  - next byte is latched as A
- TIMEOUT_TICKS=4; send A, 3 ticks, then B coincident with the 4th tick -> no o_timeout, B accepted, counter cleared.
- During WAIT_TX pulse i_rx_done with 0xFF -> ignored.
  - o_data_a unchanged
  - after i_tx_done, a fresh frame 0x01, 0x01, 0x20 yields o_tx_data=0x02.
- Assert i_rst_n=0 in WAIT_OP and in WAIT_TX -> all outputs 0 asynchronously; after release, a full frame completes normally.
- i_tx_done pulses in IDLE/WAIT_B and i_tick pulses in IDLE -> no state or output change.
